// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU issue path.
// Contents:
//   OP_MUL / OP_DIV  - one-bit op encodings carried on req_op
//   state_t          - issue sequencer state encoding
//   DIV0_ONES        - all-ones pattern returned on divide-by-zero
//                      (sliced to the datapath width by the user)
package alu_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    DRAIN,
    ABORT
  } state_t;

  localparam logic [63:0] DIV0_ONES = '1;

endpackage

// File: rtl/alu_mc_seq.sv
// alu_mc_seq - issue sequencer for the multi-cycle ALU units (divider and
// sequential multiplier). Takes one op at a time from the control unit,
// latches its operands, pulses the selected unit's start, waits for done
// (bounded by TIMEOUT) and returns result plus Z/N/C/V/err on a
// valid/ready response port. Handles divide-by-zero, timeout and flush.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   request handshake (ready only in IDLE)
//   i_req_op, i_req_a/b       op (0=MUL, 1=DIV) and operands
//   i_flush                   abandon the in-flight op
//   o_mul_start/o_div_start   one-cycle unit start pulses
//   o_unit_a/o_unit_b         latched operands to both units
//   i_mul_result/i_mul_done   multiplier return
//   i_div_result/i_div_done   divider return
//   o_rsp_valid/i_rsp_ready   response handshake
//   o_rsp_result, o_rsp_Z/N/C/V, o_rsp_err   response payload
module alu_mc_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 40,
  parameter int TO_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_req_op,
  input  logic [WIDTH-1:0] i_req_a,
  input  logic [WIDTH-1:0] i_req_b,
  input  logic             i_flush,
  output logic             o_mul_start,
  output logic             o_div_start,
  output logic [WIDTH-1:0] o_unit_a,
  output logic [WIDTH-1:0] o_unit_b,
  input  logic [WIDTH-1:0] i_mul_result,
  input  logic             i_mul_done,
  input  logic [WIDTH-1:0] i_div_result,
  input  logic             i_div_done,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_Z,
  output logic             o_rsp_N,
  output logic             o_rsp_C,
  output logic             o_rsp_V,
  output logic             o_rsp_err
);

  state_t             r_state;
  logic               r_op;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [TO_W-1:0]    r_cnt;
  logic               r_req_ready;
  logic               r_mul_start;
  logic               r_div_start;
  logic               r_rsp_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_z;
  logic               r_n;
  logic               r_c;
  logic               r_v;
  logic               r_err;

  logic               w_accept;
  logic               w_done;
  logic [WIDTH-1:0]   w_unit_res;
  logic               w_timeout;

  // A flush in IDLE blocks acceptance, so it wins over a simultaneous request.
  assign o_req_ready = r_req_ready & ~i_flush;
  assign w_accept    = i_req_valid & o_req_ready;

  // Only the unit that was launched is listened to.
  assign w_done     = (r_op == OP_DIV) ? i_div_done : i_mul_done;
  assign w_unit_res = (r_op == OP_DIV) ? i_div_result : i_mul_result;
  assign w_timeout  = (r_cnt == TO_W'(TIMEOUT));

  // Single FSM with all outputs registered. Start pulses default low every
  // cycle so they can only be high for the LAUNCH cycle. In WAIT and ABORT a
  // done in the same cycle as the timeout match wins. A flush that coincides
  // with done or timeout in WAIT goes straight to IDLE, since the unit is
  // already free and ABORT would otherwise wait for a done that never comes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_op        <= OP_MUL;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_result    <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      r_div_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op        <= i_req_op;
            r_a         <= i_req_a;
            r_b         <= i_req_b;
            r_req_ready <= 1'b0;
            if ((i_req_op == OP_DIV) && (i_req_b == '0)) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_result    <= DIV0_ONES[WIDTH-1:0];
              r_err       <= 1'b1;
              r_v         <= 1'b1;
              r_z         <= 1'b0;
              r_n         <= 1'b1;
              r_c         <= 1'b0;
            end else begin
              r_state     <= LAUNCH;
              r_mul_start <= (i_req_op == OP_MUL);
              r_div_start <= (i_req_op == OP_DIV);
            end
          end
        end
        LAUNCH: begin
          r_cnt   <= '0;
          r_state <= i_flush ? ABORT : WAIT;
        end
        WAIT: begin
          if (w_done) begin
            if (i_flush) begin
              r_state     <= IDLE;
              r_req_ready <= 1'b1;
            end else begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_result    <= w_unit_res;
              r_z         <= (w_unit_res == '0);
              r_n         <= w_unit_res[WIDTH-1];
              r_c         <= 1'b0;
              r_v         <= 1'b0;
              r_err       <= 1'b0;
            end
          end else if (w_timeout) begin
            if (i_flush) begin
              r_state     <= IDLE;
              r_req_ready <= 1'b1;
            end else begin
              r_state     <= DRAIN;
              r_rsp_valid <= 1'b1;
              r_result    <= '0;
              r_z         <= 1'b1;
              r_n         <= 1'b0;
              r_c         <= 1'b0;
              r_v         <= 1'b0;
              r_err       <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
            if (i_flush) begin
              r_state <= ABORT;
            end
          end
        end
        ABORT: begin
          if (w_done || w_timeout) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        RESP, DRAIN: begin
          if (i_flush || i_rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_mul_start  = r_mul_start;
  assign o_div_start  = r_div_start;
  assign o_unit_a     = r_a;
  assign o_unit_b     = r_b;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_result;
  assign o_rsp_Z      = r_z;
  assign o_rsp_N      = r_n;
  assign o_rsp_C      = r_c;
  assign o_rsp_V      = r_v;
  assign o_rsp_err    = r_err;

endmodule
